aes_spi_link_master: RTL and testbench

Parametrised SPI master that ships one AES job to the AES slave and collects the result. Per job: 128-bit data block, then a 128/192/256-bit key, then a configurable turnaround gap so the slave can compute, then a 128-bit result read back on MISO. Unlike the first-generation master, it adds:
- start/busy/done handshake and a runtime encrypt/decrypt selection
- a selectable bit order
- a tunable clock divider and turnaround length
- illegal-size error reporting

---
 rtl/aes_spi_link_master.sv | 176 +++++++++++++++++
 tb/tb_aes_spi_link_master.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_spi_link_master.sv
// SPI mode-0 master that ships one AES job (data block, key) to the AES slave,
// waits a turnaround gap, then reads back the 128-bit result.
module aes_spi_link_master #(
  parameter int CLK_DIV     = 50,
  parameter int TURN_CYCLES = 16,
  parameter bit LSB_FIRST   = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         mode_in,
  input  logic [1:0]   key_size,
  input  logic [127:0] data_in,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [127:0] data_out,
  output logic         sclk,
  output logic         cs_n,
  output logic         mosi,
  input  logic         miso,
  output logic         mode_out,
  output logic [1:0]   size_out
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW = $clog2(512 + TURN_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, DONE} state_t;
  state_t state, state_next;

  logic [DW-1:0]  div_cnt;
  logic [CW-1:0]  edge_cnt;
  logic [383:0]   tx_sr;
  logic [383:0]   tx_load;
  logic [127:0]   rx_sr;
  logic [CW-1:0]  key_bits;
  logic [CW-1:0]  recv_start;
  logic [CW-1:0]  total_edges;
  logic           accept;
  logic           tick;
  logic           rise_tick;
  logic           fall_tick;
  logic           last_edge;
  logic           recv_edge;

  // Edge boundaries follow the latched key size, so inputs may change while busy.
  always_comb begin
    key_bits = CW'(256);
    case (size_out)
      2'b00:   key_bits = CW'(128);
      2'b01:   key_bits = CW'(192);
      default: key_bits = CW'(256);
    endcase
    recv_start  = CW'(128) + key_bits + CW'(TURN_CYCLES);
    total_edges = recv_start + CW'(128);
  end

  assign accept    = (state == IDLE) && start && (key_size != 2'b11);
  assign tick      = ((state == SETUP) || (state == XFER)) && (div_cnt == DW'(CLK_DIV - 1));
  assign rise_tick = tick && (state == XFER) && !sclk;
  assign fall_tick = tick && (state == XFER) && sclk;
  assign last_edge = (edge_cnt == total_edges);
  // edge_cnt holds edges already made; the rising edge in progress is edge_cnt+1
  assign recv_edge = (edge_cnt >= recv_start);

  // Send image: bit 0 (LSB-first) or bit 383 (MSB-first) goes out first; unused key bits are zero.
  always_comb begin
    tx_load = '0;
    if (LSB_FIRST) begin
      case (key_size)
        2'b00:   tx_load = {128'b0, key_in[255:128], data_in};
        2'b01:   tx_load = {64'b0, key_in[255:64], data_in};
        default: tx_load = {key_in, data_in};
      endcase
    end else begin
      case (key_size)
        2'b00:   tx_load = {data_in, key_in[255:128], 128'b0};
        2'b01:   tx_load = {data_in, key_in[255:64], 64'b0};
        default: tx_load = {data_in, key_in};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    cs_n       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        cs_n = 1'b1;
        if (accept) state_next = SETUP;
      end
      SETUP: begin
        if (tick) state_next = XFER;
      end
      XFER: begin
        if (fall_tick && last_edge) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        cs_n       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      err      <= 1'b0;
      data_out <= '0;
      mode_out <= 1'b0;
      size_out <= 2'b00;
    end else begin
      err     <= (state == IDLE) && start && (key_size == 2'b11);
      div_cnt <= (tick || (state == IDLE) || (state == DONE)) ? '0 : div_cnt + 1'b1;
      case (state)
        IDLE: begin
          sclk     <= 1'b0;
          mosi     <= 1'b0;
          edge_cnt <= '0;
          if (accept) begin
            mode_out <= mode_in;
            size_out <= key_size;
            mosi     <= LSB_FIRST ? tx_load[0] : tx_load[383];
            tx_sr    <= LSB_FIRST ? (tx_load >> 1) : (tx_load << 1);
          end
        end
        SETUP: begin
          if (tick) begin
            sclk     <= 1'b1;
            edge_cnt <= CW'(1);
          end
        end
        XFER: begin
          if (rise_tick) begin
            sclk     <= 1'b1;
            edge_cnt <= edge_cnt + 1'b1;
            if (recv_edge)
              rx_sr <= LSB_FIRST ? {miso, rx_sr[127:1]} : {rx_sr[126:0], miso};
          end else if (fall_tick) begin
            sclk <= 1'b0;
            if (last_edge) begin
              mosi     <= 1'b0;
              data_out <= rx_sr;
            end else begin
              mosi  <= LSB_FIRST ? tx_sr[0] : tx_sr[383];
              tx_sr <= LSB_FIRST ? (tx_sr >> 1) : (tx_sr << 1);
            end
          end
        end
        DONE: begin
          sclk <= 1'b0;
          mosi <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_spi_link_master.sv
// Bench for aes_spi_link_master: one LSB-first and one MSB-first instance, each
// served by a behavioural SPI slave that records MOSI and returns a chosen result.
module tb_aes_spi_link_master;

  localparam int CLK_DIV = 3;
  localparam int TURN    = 16;
  localparam int BUDGET  = 8000;

  logic         clk = 1'b0;
  logic         reset;
  logic         mode_in;
  logic [1:0]   key_size;
  logic [127:0] data_in;
  logic [255:0] key_in;
  logic         start_v    [2];
  logic         miso_v     [2];
  logic         busy_v     [2];
  logic         done_v     [2];
  logic         err_v      [2];
  logic [127:0] data_out_v [2];
  logic         sclk_v     [2];
  logic         cs_n_v     [2];
  logic         mosi_v     [2];
  logic         mode_out_v [2];
  logic [1:0]   size_out_v [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  aes_spi_link_master #(.CLK_DIV(CLK_DIV), .TURN_CYCLES(TURN), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .reset(reset), .start(start_v[0]), .mode_in(mode_in), .key_size(key_size),
    .data_in(data_in), .key_in(key_in), .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]),
    .data_out(data_out_v[0]), .sclk(sclk_v[0]), .cs_n(cs_n_v[0]), .mosi(mosi_v[0]),
    .miso(miso_v[0]), .mode_out(mode_out_v[0]), .size_out(size_out_v[0]));

  aes_spi_link_master #(.CLK_DIV(CLK_DIV), .TURN_CYCLES(TURN), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .reset(reset), .start(start_v[1]), .mode_in(mode_in), .key_size(key_size),
    .data_in(data_in), .key_in(key_in), .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]),
    .data_out(data_out_v[1]), .sclk(sclk_v[1]), .cs_n(cs_n_v[1]), .mosi(mosi_v[1]),
    .miso(miso_v[1]), .mode_out(mode_out_v[1]), .size_out(size_out_v[1]));

  // Slave model state, per instance (index 0 = LSB-first, 1 = MSB-first)
  int           rises    [2] = '{0, 0};
  int           frames   [2] = '{0, 0};
  int           dones    [2] = '{0, 0};
  int           errs     [2] = '{0, 0};
  int           mode_bad [2] = '{0, 0};
  int           nkey     [2] = '{128, 128};
  logic [511:0] cap      [2];
  logic [127:0] resp     [2];
  logic         mode_exp [2] = '{1'b0, 1'b0};
  logic [1:0]   size_exp [2] = '{2'b00, 2'b00};
  logic         prev_sclk[2] = '{1'b0, 1'b0};
  logic         prev_cs  [2] = '{1'b1, 1'b1};

  // Bit the slave drives for rising edge e (1-based); outside RECV it sends noise.
  function automatic logic slave_bit(input int u, input int e);
    int st;
    int i;
    st = 128 + nkey[u] + TURN;
    if (e > st && e <= st + 128) begin
      i = e - st;
      return (u == 0) ? resp[u][i-1] : resp[u][128-i];
    end
    return 1'($urandom_range(1, 0));
  endfunction

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (cs_n_v[u] === 1'b0 && prev_cs[u] === 1'b1) begin
        frames[u]++;
        rises[u] = 0;
        cap[u]   = '0;
        nkey[u]  = 128 + 64 * int'(size_out_v[u]);
        miso_v[u] = slave_bit(u, 1);
      end
      if (sclk_v[u] === 1'b1 && prev_sclk[u] === 1'b0) begin
        if (rises[u] < 512) cap[u][rises[u]] = mosi_v[u];
        rises[u]++;
      end
      if (sclk_v[u] === 1'b0 && prev_sclk[u] === 1'b1 && cs_n_v[u] === 1'b0)
        miso_v[u] = slave_bit(u, rises[u] + 1);
      if (done_v[u] === 1'b1) dones[u]++;
      if (err_v[u] === 1'b1) errs[u]++;
      if (cs_n_v[u] === 1'b0 && (mode_out_v[u] !== mode_exp[u] || size_out_v[u] !== size_exp[u]))
        mode_bad[u]++;
      prev_sclk[u] = sclk_v[u];
      prev_cs[u]   = cs_n_v[u];
    end
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transmit order derived directly from the field/bit-order rules.
  function automatic logic [511:0] exp_send(input bit lsb, input logic [127:0] d,
                                            input logic [255:0] k, input logic [1:0] ks);
    logic [511:0] v;
    int n;
    v = '0;
    n = 128 + 64 * int'(ks);
    for (int i = 0; i < 128; i++) v[i] = lsb ? d[i] : d[127-i];
    for (int j = 0; j < n; j++) v[128+j] = lsb ? k[256-n+j] : k[255-j];
    return v;
  endfunction

  task automatic start_job(input int u, input logic [127:0] d, input logic [255:0] k,
                           input logic [1:0] ks, input logic md, input logic [127:0] r);
    resp[u]     = r;
    mode_exp[u] = md;
    size_exp[u] = ks;
    data_in     = d;
    key_in      = k;
    key_size    = ks;
    mode_in     = md;
    @(negedge clk); #1;
    start_v[u] = 1'b1;
    @(negedge clk); #1;
    start_v[u] = 1'b0;
    data_in  = {$urandom, $urandom, $urandom, $urandom};
    key_in   = {8{$urandom}};
    key_size = 2'($urandom_range(3, 0));
    mode_in  = ~md;
  endtask

  task automatic wait_done(input int u, input string tag);
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      @(negedge clk); #1;
      if (done_v[u] === 1'b1) break;
    end
    chk({tag, "_done"}, 512'(done_v[u]), 512'(1));
  endtask

  task automatic check_job(input int u, input logic [127:0] d, input logic [255:0] k,
                           input logic [1:0] ks, input logic [127:0] r, input string tag);
    logic [511:0] mask;
    int n;
    n = 128 + 64 * int'(ks);
    mask = '0;
    for (int i = 0; i < 128 + n + TURN; i++) mask[i] = 1'b1;
    chk({tag, "_data_out"}, 512'(data_out_v[u]), 512'(r));
    chk({tag, "_rises"}, 512'(rises[u]), 512'(256 + n + TURN));
    chk({tag, "_mosi"}, cap[u] & mask, exp_send(u == 0, d, k, ks));
  endtask

  task automatic run_job(input int u, input logic [127:0] d, input logic [255:0] k,
                         input logic [1:0] ks, input logic md, input logic [127:0] r,
                         input string tag);
    start_job(u, d, k, ks, md, r);
    wait_done(u, tag);
    check_job(u, d, k, ks, r, tag);
  endtask

  initial begin
    logic [127:0] d1, d2, r1, r2;
    logic [255:0] k1, k2;
    logic [1:0]   ks;
    int f0, dn0, e0;

    start_v  = '{1'b0, 1'b0};
    miso_v   = '{1'b0, 1'b0};
    mode_in  = 1'b0;
    key_size = 2'b00;
    data_in  = '0;
    key_in   = '0;
    reset    = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("rst_cs_n", 512'(cs_n_v[u]), 512'(1));
      chk("rst_sclk_mosi", 512'({sclk_v[u], mosi_v[u]}), 512'(0));
      chk("rst_busy_done_err", 512'({busy_v[u], done_v[u], err_v[u]}), 512'(0));
      chk("rst_data_out", 512'(data_out_v[u]), 512'(0));
      chk("rst_mode_size", 512'({mode_out_v[u], size_out_v[u]}), 512'(0));
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: AES-128 encrypt, LSB first
    run_job(0, 128'h3243f6a8885a308d313198a2e0370734, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
            2'b00, 1'b0, 128'h3925841d02dc09fbdc118597196a0b32, "t1");
    chk("t1_first_mosi", 512'(cap[0][0]), 512'(0));
    repeat (3) @(negedge clk); #1;
    chk("t1_one_done", 512'(dones[0]), 512'(1));
    chk("t1_busy_low", 512'(busy_v[0]), 512'(0));

    // 2: AES-256 decrypt
    run_job(0, 128'h8ea2b7ca516745bfeafc49904b496089,
            256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
            2'b10, 1'b1, 128'h00112233445566778899aabbccddeeff, "t2");
    chk("t2_mode_stable", 512'(mode_bad[0]), 512'(0));

    // 3: illegal key size
    e0 = errs[0]; f0 = frames[0];
    key_size = 2'b11; mode_in = 1'b0;
    @(negedge clk); #1;
    start_v[0] = 1'b1;
    @(negedge clk); #1;
    start_v[0] = 1'b0;
    chk("t3_err_high", 512'(err_v[0]), 512'(1));
    chk("t3_idle_bus", 512'({cs_n_v[0], sclk_v[0], busy_v[0]}), 512'(3'b100));
    @(negedge clk); #1;
    chk("t3_err_low", 512'(err_v[0]), 512'(0));
    repeat (10) @(negedge clk); #1;
    chk("t3_err_count", 512'(errs[0] - e0), 512'(1));
    chk("t3_no_frame", 512'(frames[0] - f0), 512'(0));
    chk("t3_idle_bus_later", 512'({cs_n_v[0], sclk_v[0], busy_v[0]}), 512'(3'b100));

    // 4: AES-192, MSB first
    run_job(1, {$urandom, $urandom, $urandom, $urandom}, {8{$urandom}}, 2'b01, 1'b0,
            {$urandom, $urandom, $urandom, $urandom}, "t4");
    d1 = {$urandom, $urandom, $urandom, $urandom};
    k1 = {8{$urandom}};
    run_job(1, d1, k1, 2'b01, 1'b1, {$urandom, $urandom, $urandom, $urandom}, "t4b");

    // 5: reset mid-frame
    start_job(0, {$urandom, $urandom, $urandom, $urandom}, {8{$urandom}}, 2'b00, 1'b0,
              {$urandom, $urandom, $urandom, $urandom});
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      @(negedge clk); #1;
      if (rises[0] >= 200) break;
    end
    chk("t5_reached_200", 512'(rises[0] >= 200), 512'(1));
    reset = 1'b1;
    @(negedge clk); #1;
    chk("t5_cs_sclk_busy", 512'({cs_n_v[0], sclk_v[0], busy_v[0]}), 512'(3'b100));
    chk("t5_data_out", 512'(data_out_v[0]), 512'(0));
    reset = 1'b0;
    @(negedge clk);
    run_job(0, {$urandom, $urandom, $urandom, $urandom}, {8{$urandom}}, 2'b01, 1'b1,
            {$urandom, $urandom, $urandom, $urandom}, "t5_after");

    // 6: starts while busy and on the done cycle are ignored; start right after is taken
    f0 = frames[0]; dn0 = dones[0]; e0 = errs[0];
    d1 = {$urandom, $urandom, $urandom, $urandom}; k1 = {8{$urandom}};
    r1 = {$urandom, $urandom, $urandom, $urandom};
    d2 = {$urandom, $urandom, $urandom, $urandom}; k2 = {8{$urandom}};
    r2 = {$urandom, $urandom, $urandom, $urandom};
    start_job(0, d1, k1, 2'b00, 1'b0, r1);
    repeat (100) @(negedge clk);
    #1;
    key_size = 2'b11;
    start_v[0] = 1'b1;
    @(negedge clk); #1;
    key_size = 2'b10;
    @(negedge clk); #1;
    start_v[0] = 1'b0;
    wait_done(0, "t6a");
    check_job(0, d1, k1, 2'b00, r1, "t6a");
    resp[0] = r2; mode_exp[0] = 1'b1; size_exp[0] = 2'b10;
    data_in = d2; key_in = k2; key_size = 2'b10; mode_in = 1'b1;
    start_v[0] = 1'b1;
    @(negedge clk); #1;
    chk("t6_busy_low_after_done", 512'(busy_v[0]), 512'(0));
    chk("t6_cs_high_after_done", 512'(cs_n_v[0]), 512'(1));
    @(negedge clk); #1;
    start_v[0] = 1'b0;
    chk("t6_second_busy", 512'(busy_v[0]), 512'(1));
    wait_done(0, "t6b");
    check_job(0, d2, k2, 2'b10, r2, "t6b");
    repeat (3) @(negedge clk); #1;
    chk("t6_frames", 512'(frames[0] - f0), 512'(2));
    chk("t6_dones", 512'(dones[0] - dn0), 512'(2));
    chk("t6_no_err", 512'(errs[0] - e0), 512'(0));

    // Randomized jobs on both bit orders
    for (int t = 0; t < 4; t++) begin
      ks = 2'($urandom_range(2, 0));
      run_job(t % 2, {$urandom, $urandom, $urandom, $urandom}, {8{$urandom}}, ks,
              1'($urandom_range(1, 0)), {$urandom, $urandom, $urandom, $urandom}, "rand");
    end
    repeat (3) @(negedge clk); #1;
    chk("mode_size_stable_all", 512'(mode_bad[0] + mode_bad[1]), 512'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
